// File: rtl/lzw_code_packer_if.sv
// rtl/lzw_code_packer_if.sv - block-control and FIFO handshake bundle for lzw_code_packer
// Ports carried: ap_start/ap_continue/ap_done/ap_idle/ap_ready block control,
// code FIFO (outstream_*), code-count FIFO (outlen_stream_*), byte FIFO (outArr_*),
// byte-count FIFO (len_*), and the four active-low *_blk_n stall indicators.
// master = the packer, slave = the surrounding dataflow/FIFO environment.
interface lzw_code_packer_if #(
    parameter int CODE_W = 13,
    parameter int CNT_W  = 32
) ();
    logic              ap_start;
    logic              ap_continue;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [CODE_W-1:0] outstream_dout;
    logic              outstream_empty_n;
    logic              outstream_read;
    logic [CNT_W-1:0]  outlen_stream_dout;
    logic              outlen_stream_empty_n;
    logic              outlen_stream_read;
    logic [7:0]        outArr_din;
    logic              outArr_full_n;
    logic              outArr_write;
    logic [CNT_W-1:0]  len_din;
    logic              len_full_n;
    logic              len_write;
    logic              outstream_blk_n;
    logic              outlen_stream_blk_n;
    logic              outArr_blk_n;
    logic              len_blk_n;

    modport master (
        input  ap_start, ap_continue,
        input  outstream_dout, outstream_empty_n,
        input  outlen_stream_dout, outlen_stream_empty_n,
        input  outArr_full_n, len_full_n,
        output ap_done, ap_idle, ap_ready,
        output outstream_read, outlen_stream_read,
        output outArr_din, outArr_write, len_din, len_write,
        output outstream_blk_n, outlen_stream_blk_n, outArr_blk_n, len_blk_n
    );

    modport slave (
        output ap_start, ap_continue,
        output outstream_dout, outstream_empty_n,
        output outlen_stream_dout, outlen_stream_empty_n,
        output outArr_full_n, len_full_n,
        input  ap_done, ap_idle, ap_ready,
        input  outstream_read, outlen_stream_read,
        input  outArr_din, outArr_write, len_din, len_write,
        input  outstream_blk_n, outlen_stream_blk_n, outArr_blk_n, len_blk_n
    );
endinterface

// File: rtl/lzw_code_packer.sv
// rtl/lzw_code_packer.sv - packs one chunk of LZW codes MSB-first into bytes and reports the byte count
// Ports: ap_clk (clock), ap_rst (synchronous active-high reset),
// bus (lzw_code_packer_if.master): ap_ctrl_chain control, code/count input FIFOs,
// byte/length output FIFOs and *_blk_n stall indicators.
module lzw_code_packer #(
    parameter int CODE_W = 13,
    parameter int CNT_W  = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    lzw_code_packer_if.master bus
);
    localparam int ACC_W = CODE_W + 7;
    localparam int NB_W  = $clog2(CODE_W + 8);

    typedef enum logic [2:0] {IDLE, RDLEN, PACK, FLUSH, WRLEN, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [ACC_W-1:0] acc;
    logic [NB_W-1:0]  nbits;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] bcnt;

    logic             want_len_in;
    logic             want_code;
    logic             want_byte;
    logic             want_len_out;
    logic [7:0]       byte_val;
    logic             have_byte;
    logic [ACC_W-1:0] acc_sh;
    logic [3:0]       pad;
    logic             len_rd;
    logic             code_rd;
    logic             byte_wr;
    logic             len_wr;

    assign have_byte = nbits >= NB_W'(8);
    // Oldest unsent byte sits at acc[nbits-1 -: 8]; shifting it down keeps the select constant.
    assign acc_sh    = acc >> (nbits - NB_W'(8));
    // Only used in FLUSH where nbits < 8, so the pad amount fits in 4 bits.
    assign pad       = 4'd8 - 4'(nbits);

    always_comb begin
        next_state   = state;
        want_len_in  = 1'b0;
        want_code    = 1'b0;
        want_byte    = 1'b0;
        want_len_out = 1'b0;
        byte_val     = '0;
        case (state)
            IDLE: begin
                if (bus.ap_start) next_state = RDLEN;
            end
            RDLEN: begin
                want_len_in = 1'b1;
                if (bus.outlen_stream_empty_n) next_state = PACK;
            end
            PACK: begin
                // Draining a full byte takes priority so acc never has to hold more than CODE_W+7 bits.
                if (have_byte) begin
                    want_byte = 1'b1;
                    byte_val  = acc_sh[7:0];
                end else if (rem != '0) begin
                    want_code = 1'b1;
                end else begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (nbits != '0) begin
                    want_byte = 1'b1;
                    byte_val  = acc[7:0] << pad;
                    if (bus.outArr_full_n) next_state = WRLEN;
                end else begin
                    next_state = WRLEN;
                end
            end
            WRLEN: begin
                want_len_out = 1'b1;
                if (bus.len_full_n) next_state = DONE;
            end
            DONE: begin
                if (bus.ap_continue) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes are masked during reset so an interrupted chunk never pops or pushes on the reset edge.
    assign len_rd  = want_len_in & bus.outlen_stream_empty_n & ~ap_rst;
    assign code_rd = want_code & bus.outstream_empty_n & ~ap_rst;
    assign byte_wr = want_byte & bus.outArr_full_n & ~ap_rst;
    assign len_wr  = want_len_out & bus.len_full_n & ~ap_rst;

    assign bus.outlen_stream_read  = len_rd;
    assign bus.outstream_read      = code_rd;
    assign bus.outArr_write        = byte_wr;
    assign bus.outArr_din          = byte_val;
    assign bus.len_write           = len_wr;
    assign bus.len_din             = want_len_out ? bcnt : '0;
    assign bus.ap_ready            = len_wr;
    assign bus.ap_idle             = (state == IDLE);
    assign bus.ap_done             = (state == DONE);
    assign bus.outlen_stream_blk_n = ~(want_len_in & ~bus.outlen_stream_empty_n);
    assign bus.outstream_blk_n     = ~(want_code & ~bus.outstream_empty_n);
    assign bus.outArr_blk_n        = ~(want_byte & ~bus.outArr_full_n);
    assign bus.len_blk_n           = ~(want_len_out & ~bus.len_full_n);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc   <= '0;
            nbits <= '0;
            rem   <= '0;
            bcnt  <= '0;
        end else begin
            if (state == IDLE && bus.ap_start) begin
                acc   <= '0;
                nbits <= '0;
                bcnt  <= '0;
            end
            if (len_rd) rem <= bus.outlen_stream_dout;
            if (code_rd) begin
                acc   <= {acc[ACC_W-CODE_W-1:0], bus.outstream_dout};
                nbits <= nbits + NB_W'(CODE_W);
                rem   <= rem - CNT_W'(1);
            end
            if (byte_wr) begin
                bcnt <= bcnt + CNT_W'(1);
                if (state == PACK) nbits <= nbits - NB_W'(8);
            end
        end
    end
endmodule

// File: tb/tb_lzw_code_packer.sv
// tb/tb_lzw_code_packer.sv - self-checking bench for lzw_code_packer
module tb_lzw_code_packer;
    localparam int CODE_W = 13;
    localparam int CNT_W  = 32;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    lzw_code_packer_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();
    lzw_code_packer #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));

    int total = 0;
    int bad = 0;

    logic [CODE_W-1:0] chunk[$];
    logic [CODE_W-1:0] code_q[$];
    logic [CNT_W-1:0]  nlen_q[$];
    logic [7:0]        exp_q[$];
    logic [7:0]        got_q[$];
    logic [CNT_W-1:0]  got_len[$];

    int ready_cnt = 0, code_reads = 0, len_reads = 0;
    int out_thr = 0, in_thr = 0, starve_left = 0;
    bit starving = 0;
    int starve_reads = 0, starve_blk_low = 0;
    int oa_blk_low = 0, oa_blk_bad = 0, os_blk_bad = 0;

    // FIFO environment: flags change on the falling edge, transfers are recorded 1 ns later.
    always @(negedge ap_clk) begin
        bus.outArr_full_n = ($urandom_range(99) >= out_thr);
        bus.len_full_n    = 1'b1;
        if (starve_left > 0) begin
            starving = 1;
            starve_left--;
            bus.outstream_empty_n = 1'b0;
        end else begin
            starving = 0;
            bus.outstream_empty_n = (code_q.size() > 0) && ($urandom_range(99) >= in_thr);
        end
        bus.outstream_dout        = (code_q.size() > 0) ? code_q[0] : CODE_W'($urandom);
        bus.outlen_stream_empty_n = (nlen_q.size() > 0);
        bus.outlen_stream_dout    = (nlen_q.size() > 0) ? nlen_q[0] : '0;
        #1;
        if (bus.outstream_read) begin
            if (code_q.size() > 0) void'(code_q.pop_front());
            code_reads++;
            if (starving) starve_reads++;
        end
        if (bus.outlen_stream_read) begin
            if (nlen_q.size() > 0) void'(nlen_q.pop_front());
            len_reads++;
        end
        if (bus.outArr_write) got_q.push_back(bus.outArr_din);
        if (bus.len_write) got_len.push_back(bus.len_din);
        if (bus.ap_ready) ready_cnt++;
        if (!bus.outArr_blk_n) begin
            oa_blk_low++;
            if (bus.outArr_full_n) oa_blk_bad++;
        end
        if (!bus.outstream_blk_n) begin
            if (bus.outstream_empty_n) os_blk_bad++;
            if (starving) starve_blk_low++;
        end
    end

    // Reference: concatenate codes as a bit string MSB-first, zero-pad to a byte multiple, cut into bytes.
    function automatic void add_expected();
        logic bits[$];
        logic [7:0] b;
        foreach (chunk[i]) for (int k = CODE_W - 1; k >= 0; k--) bits.push_back(chunk[i][k]);
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        for (int i = 0; i < bits.size(); i += 8) begin
            for (int k = 0; k < 8; k++) b[7-k] = bits[i+k];
            exp_q.push_back(b);
        end
    endfunction

    function automatic int byte_errs();
        int e = 0;
        if (got_q.size() != exp_q.size()) return 1000;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    function automatic int ceil_bytes(input int n);
        return (n * CODE_W + 7) / 8;
    endfunction

    task automatic clear_capture();
        exp_q.delete(); got_q.delete(); got_len.delete(); ready_cnt = 0;
    endtask

    task automatic load_chunk();
        foreach (chunk[i]) code_q.push_back(chunk[i]);
        nlen_q.push_back(CNT_W'(chunk.size()));
        add_expected();
    endtask

    task automatic start_chunk();
        clear_capture();
        load_chunk();
        @(negedge ap_clk); bus.ap_start = 1'b1;
        @(negedge ap_clk); bus.ap_start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit to);
        cycles = 1; to = 1;
        for (int i = 0; i < 3000; i++) begin
            #2;
            if (bus.ap_done) begin to = 0; break; end
            @(negedge ap_clk);
            cycles++;
        end
    endtask

    task automatic ack_done();
        @(negedge ap_clk); bus.ap_continue = 1'b1;
        @(negedge ap_clk); bus.ap_continue = 1'b0;
    endtask

    task automatic rand_chunk(input int n);
        chunk.delete();
        for (int i = 0; i < n; i++) chunk.push_back(CODE_W'($urandom));
    endtask

    task automatic test_reset();
        @(negedge ap_clk); ap_rst = 1'b0; #2;
        total++; if (bus.ap_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", bus.ap_idle); end
        total++; if ({bus.ap_done, bus.ap_ready, bus.outstream_read, bus.outlen_stream_read, bus.outArr_write, bus.len_write} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes got=%b exp=000000", {bus.ap_done, bus.ap_ready, bus.outstream_read, bus.outlen_stream_read, bus.outArr_write, bus.len_write}); end
        total++; if ({bus.outArr_din, bus.len_din} !== 40'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {bus.outArr_din, bus.len_din}); end
        total++; if ({bus.outstream_blk_n, bus.outlen_stream_blk_n, bus.outArr_blk_n, bus.len_blk_n} !== 4'hF) begin
            bad++; $display("FAIL reset_blk_n got=%b exp=1111", {bus.outstream_blk_n, bus.outlen_stream_blk_n, bus.outArr_blk_n, bus.len_blk_n}); end
    endtask

    task automatic test_single_max();
        int cyc; bit to;
        chunk = '{13'h1FFF};
        start_chunk(); wait_done(cyc, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout got=no_done exp=done"); end
        total++; if (cyc != 7) begin bad++; $display("FAIL single_latency got=%0d exp=7", cyc); end
        total++; if (!(got_q.size() == 2 && got_q[0] == 8'hFF && got_q[1] == 8'hF8)) begin bad++; $display("FAIL single_bytes got_n=%0d exp=FF,F8", got_q.size()); end
        total++; if (!(got_len.size() == 1 && got_len[0] == 2)) begin bad++; $display("FAIL single_len got_n=%0d exp=2", got_len.size()); end
        repeat (3) @(negedge ap_clk); #2;
        total++; if (bus.ap_done !== 1'b1) begin bad++; $display("FAIL done_held got=%b exp=1", bus.ap_done); end
        ack_done(); #2;
        total++; if (bus.ap_idle !== 1'b1) begin bad++; $display("FAIL continue_idle got=%b exp=1", bus.ap_idle); end
    endtask

    task automatic test_two_codes();
        int cyc; bit to;
        chunk = '{13'h041, 13'h042};
        start_chunk(); wait_done(cyc, to);
        total++; if (to) begin bad++; $display("FAIL two_timeout got=no_done exp=done"); end
        total++; if (!(got_q.size() == 4 && got_q[0] == 8'h02 && got_q[1] == 8'h08 && got_q[2] == 8'h10 && got_q[3] == 8'h80)) begin
            bad++; $display("FAIL two_bytes got_n=%0d exp=02,08,10,80", got_q.size()); end
        total++; if (!(got_len.size() == 1 && got_len[0] == 4)) begin bad++; $display("FAIL two_len got_n=%0d exp=4", got_len.size()); end
        ack_done();
    endtask

    task automatic test_empty();
        int cyc, lr; bit to;
        chunk.delete();
        start_chunk(); wait_done(cyc, to);
        total++; if (to) begin bad++; $display("FAIL empty_timeout got=no_done exp=done"); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL empty_bytes got=%0d exp=0", got_q.size()); end
        total++; if (!(got_len.size() == 1 && got_len[0] == 0)) begin bad++; $display("FAIL empty_len got_n=%0d exp=1 word of 0", got_len.size()); end
        total++; if (ready_cnt != 1) begin bad++; $display("FAIL empty_ready got=%0d exp=1", ready_cnt); end
        lr = len_reads;
        @(negedge ap_clk); bus.ap_start = 1'b1;
        repeat (3) @(negedge ap_clk);
        bus.ap_start = 1'b0; #2;
        total++; if (bus.ap_done !== 1'b1 || len_reads != lr) begin bad++; $display("FAIL start_in_done got done=%b reads=%0d exp done=1 reads=%0d", bus.ap_done, len_reads, lr); end
        ack_done();
    endtask

    task automatic test_exact_boundary();
        int cyc; bit to;
        chunk.delete();
        for (int i = 0; i < 8; i++) chunk.push_back(13'h1555);
        out_thr = 50; oa_blk_low = 0; oa_blk_bad = 0;
        start_chunk(); wait_done(cyc, to);
        out_thr = 0;
        total++; if (to) begin bad++; $display("FAIL exact_timeout got=no_done exp=done"); end
        total++; if (byte_errs() != 0 || got_q.size() != 13) begin bad++; $display("FAIL exact_bytes got_n=%0d errs=%0d exp_n=13", got_q.size(), byte_errs()); end
        total++; if (!(got_len.size() == 1 && got_len[0] == CNT_W'(ceil_bytes(8)))) begin bad++; $display("FAIL exact_len got_n=%0d exp=13", got_len.size()); end
        total++; if (oa_blk_bad != 0 || oa_blk_low == 0) begin bad++; $display("FAIL exact_blk got bad=%0d low=%0d exp bad=0 low>0", oa_blk_bad, oa_blk_low); end
        ack_done();
    endtask

    task automatic test_starve();
        int cyc; bit to;
        rand_chunk(10);
        starve_reads = 0; starve_blk_low = 0; os_blk_bad = 0;
        start_chunk();
        for (int i = 0; i < 200; i++) begin #2; if (got_q.size() >= 2) break; @(negedge ap_clk); end
        starve_left = 10;
        wait_done(cyc, to);
        total++; if (to) begin bad++; $display("FAIL starve_timeout got=no_done exp=done"); end
        total++; if (starve_reads != 0) begin bad++; $display("FAIL starve_reads got=%0d exp=0", starve_reads); end
        total++; if (starve_blk_low < 8 || os_blk_bad != 0) begin bad++; $display("FAIL starve_blk got low=%0d bad=%0d exp low>=8 bad=0", starve_blk_low, os_blk_bad); end
        total++; if (byte_errs() != 0) begin bad++; $display("FAIL starve_bytes got_n=%0d errs=%0d exp_n=%0d", got_q.size(), byte_errs(), exp_q.size()); end
        ack_done();
    endtask

    task automatic test_random();
        int cyc, n; bit to;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(0, 20);
            rand_chunk(n);
            in_thr = $urandom_range(0, 60); out_thr = $urandom_range(0, 60);
            start_chunk(); wait_done(cyc, to);
            in_thr = 0; out_thr = 0;
            total++; if (to || byte_errs() != 0) begin bad++; $display("FAIL random_bytes n=%0d got_n=%0d errs=%0d exp_n=%0d", n, got_q.size(), byte_errs(), exp_q.size()); end
            total++; if (!(got_len.size() == 1 && got_len[0] == CNT_W'(ceil_bytes(n)))) begin bad++; $display("FAIL random_len n=%0d got_n=%0d exp=%0d", n, got_len.size(), ceil_bytes(n)); end
            ack_done();
        end
    endtask

    task automatic test_reset_mid();
        int cyc, snap_r, snap_b; bit to;
        rand_chunk(4);
        start_chunk();
        for (int i = 0; i < 200; i++) begin #2; if (got_q.size() >= 3) break; @(negedge ap_clk); end
        @(negedge ap_clk); ap_rst = 1'b1;
        snap_r = code_reads + len_reads; snap_b = got_q.size();
        #2;
        total++; if (code_reads + len_reads != snap_r || got_q.size() != snap_b) begin
            bad++; $display("FAIL reset_cycle_xfer got reads=%0d bytes=%0d exp reads=%0d bytes=%0d", code_reads + len_reads, got_q.size(), snap_r, snap_b); end
        @(negedge ap_clk); ap_rst = 1'b0; #2;
        total++; if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.outArr_write !== 1'b0 || bus.len_din !== '0) begin
            bad++; $display("FAIL midreset_state got idle=%b done=%b wr=%b len=%0d exp 1,0,0,0", bus.ap_idle, bus.ap_done, bus.outArr_write, bus.len_din); end
        total++; if ({bus.outstream_blk_n, bus.outlen_stream_blk_n, bus.outArr_blk_n, bus.len_blk_n} !== 4'hF) begin
            bad++; $display("FAIL midreset_blk_n got=%b exp=1111", {bus.outstream_blk_n, bus.outlen_stream_blk_n, bus.outArr_blk_n, bus.len_blk_n}); end
        code_q.delete(); nlen_q.delete();
        rand_chunk(1);
        start_chunk(); wait_done(cyc, to);
        total++; if (to || byte_errs() != 0 || got_q.size() != 2) begin bad++; $display("FAIL after_reset_bytes got_n=%0d errs=%0d exp_n=2", got_q.size(), byte_errs()); end
        ack_done();
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        n1 = $urandom_range(1, 6); n2 = $urandom_range(1, 6);
        clear_capture();
        rand_chunk(n1); load_chunk();
        rand_chunk(n2); load_chunk();
        @(negedge ap_clk); bus.ap_continue = 1'b1; bus.ap_start = 1'b1;
        for (int i = 0; i < 500; i++) begin @(negedge ap_clk); #2; if (ready_cnt >= 2) break; end
        @(negedge ap_clk); bus.ap_start = 1'b0;
        repeat (3) @(negedge ap_clk); #2;
        total++; if (!(got_len.size() == 2 && got_len[0] == CNT_W'(ceil_bytes(n1)) && got_len[1] == CNT_W'(ceil_bytes(n2)))) begin
            bad++; $display("FAIL b2b_len got_n=%0d exp=%0d,%0d", got_len.size(), ceil_bytes(n1), ceil_bytes(n2)); end
        total++; if (byte_errs() != 0) begin bad++; $display("FAIL b2b_bytes got_n=%0d errs=%0d exp_n=%0d", got_q.size(), byte_errs(), exp_q.size()); end
        total++; if (bus.ap_idle !== 1'b1 || ready_cnt != 2) begin bad++; $display("FAIL b2b_end got idle=%b ready=%0d exp idle=1 ready=2", bus.ap_idle, ready_cnt); end
        bus.ap_continue = 1'b0;
    endtask

    initial begin
        bus.ap_start = 1'b0; bus.ap_continue = 1'b0;
        bus.outstream_empty_n = 1'b0; bus.outlen_stream_empty_n = 1'b0;
        bus.outArr_full_n = 1'b1; bus.len_full_n = 1'b1;
        bus.outstream_dout = '0; bus.outlen_stream_dout = '0;
        ap_rst = 1'b1;
        repeat (3) @(negedge ap_clk);
        test_reset();
        test_single_max();
        test_two_codes();
        test_empty();
        test_exact_boundary();
        test_starve();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
